mmio_uart_tx: RTL and testbench

Memory-mapped, parametrised UART transmitter on the RV32I data-memory bus. It replaces the bare "print on store to 0xf0000010" console with real hardware: a TX FIFO, a programmable baud divisor, a serial `txd` line and a readable status register. It sits beside the data `Memory` in the data-bus decode and reuses the `dm*` bus signal semantics.

---
 rtl/mmio_uart_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/mmio_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents: register offsets relative to BASE, STATUS bit positions,
// TX state encoding and the console data address used by bus monitors.
package mmio_uart_pkg;

    localparam logic [31:0] DATA_OFFSET    = 32'h10;
    localparam logic [31:0] STATUS_OFFSET  = 32'h14;
    localparam logic [31:0] DIV_OFFSET     = 32'h18;

    // Absolute DATA register address for the default BASE.
    localparam logic [31:0] UART_DATA_ADDR = 32'hf000_0010;

    localparam int unsigned STATUS_FULL      = 0;
    localparam int unsigned STATUS_EMPTY     = 1;
    localparam int unsigned STATUS_BUSY      = 2;
    localparam int unsigned STATUS_OVERFLOW  = 3;
    localparam int unsigned STATUS_LEVEL_LSB = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } txState_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy level.
// Ports:
//   clock, reset      - clock and asynchronous active-high reset
//   push, pushData    - write request and data; ignored when full
//   pop, popData      - read request; popData shows the head entry
//   full, empty       - occupancy flags
//   level             - entry count, one bit wider than the pointers
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full    = (level == LEVEL_FULL);
    assign empty   = (level == '0);
    // Both gated on pre-edge flags: a full FIFO drops a push even if it pops.
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign popData = mem[rdPtr];

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            level <= level + LW'(doPush) - LW'(doPop);
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter on the data bus.
// Ports:
//   clock, reset   - clock and asynchronous active-high reset
//   address        - byte address, full 32-bit compare against BASE+offset
//   func3          - store width, unused (only the low byte matters)
//   write, dataIn  - store strobe and store data
//   dataOut        - combinational read data (STATUS, DIV; others read 0)
//   txd            - registered serial output, idle high
//   busy           - FIFO non-empty or frame in flight
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'hf000_0000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd4,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [2:0]  func3,
    input  logic        write,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        txd,
    output logic        busy
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    logic                 dataSel;
    logic                 statusSel;
    logic                 divSel;
    logic                 pushReq;
    logic                 fifoPop;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic [DATA_BITS-1:0] fifoHead;
    logic [LW-1:0]        fifoLevel;
    logic [15:0]          levelWide;
    logic [31:0]          status;
    logic [15:0]          divReg;
    logic                 overflow;
    txState_e             state;
    logic [15:0]          bitCnt;
    logic [3:0]           bitIdx;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 unusedBits;

    assign unusedBits = ^{func3, dataIn[31:16]};

    assign dataSel   = (address == BASE + DATA_OFFSET);
    assign statusSel = (address == BASE + STATUS_OFFSET);
    assign divSel    = (address == BASE + DIV_OFFSET);
    assign pushReq   = write && dataSel;

    // The FSM only pops from IDLE, so a byte pushed into an empty FIFO
    // is taken one edge later.
    assign fifoPop   = (state == StIdle) && !fifoEmpty;
    assign busy      = !fifoEmpty || (state != StIdle);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) txFifo (
        .clock    (clock),
        .reset    (reset),
        .push     (pushReq),
        .pushData (dataIn[DATA_BITS-1:0]),
        .pop      (fifoPop),
        .popData  (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .level    (fifoLevel)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            divReg   <= DIV_RESET;
            overflow <= 1'b0;
        end else begin
            if (write && divSel) begin
                divReg <= (dataIn[15:0] == 16'd0) ? 16'd1 : dataIn[15:0];
            end
            if (pushReq && fifoFull) begin
                overflow <= 1'b1;
            end else if (write && statusSel && dataIn[STATUS_OVERFLOW]) begin
                overflow <= 1'b0;
            end
        end
    end

    assign levelWide = 16'(fifoLevel);

    always_comb begin
        status = '0;
        status[STATUS_FULL]     = fifoFull;
        status[STATUS_EMPTY]    = fifoEmpty;
        status[STATUS_BUSY]     = busy;
        status[STATUS_OVERFLOW] = overflow;
        status[STATUS_LEVEL_LSB +: 8] = levelWide[7:0];
    end

    always_comb begin
        dataOut = '0;
        if (statusSel) begin
            dataOut = status;
        end else if (divSel) begin
            dataOut = {16'h0000, divReg};
        end
    end

    // bitCnt counts down the clocks of the current bit; it is reloaded from
    // divReg only at bit boundaries, so a DIV write never alters a bit in
    // progress. txd is registered alongside the state it belongs to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            txd      <= 1'b1;
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            case (state)
                StIdle: begin
                    txd <= 1'b1;
                    if (!fifoEmpty) begin
                        shiftReg <= fifoHead;
                        bitCnt   <= divReg - 16'd1;
                        state    <= StStart;
                        txd      <= 1'b0;
                    end
                end
                StStart: begin
                    if (bitCnt == 16'd0) begin
                        bitCnt <= divReg - 16'd1;
                        bitIdx <= '0;
                        state  <= StData;
                        txd    <= shiftReg[0];
                    end else begin
                        bitCnt <= bitCnt - 16'd1;
                    end
                end
                StData: begin
                    if (bitCnt == 16'd0) begin
                        bitCnt <= divReg - 16'd1;
                        if (bitIdx == LAST_DATA) begin
                            bitIdx <= '0;
                            state  <= StStop;
                            txd    <= 1'b1;
                        end else begin
                            bitIdx   <= bitIdx + 4'd1;
                            shiftReg <= shiftReg >> 1;
                            txd      <= shiftReg[1];
                        end
                    end else begin
                        bitCnt <= bitCnt - 16'd1;
                    end
                end
                StStop: begin
                    if (bitCnt == 16'd0) begin
                        if (bitIdx == LAST_STOP) begin
                            state <= StIdle;
                            txd   <= 1'b1;
                        end else begin
                            bitIdx <= bitIdx + 4'd1;
                            bitCnt <= divReg - 16'd1;
                        end
                    end else begin
                        bitCnt <= bitCnt - 16'd1;
                    end
                end
                default: begin
                    state <= StIdle;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. Bus writes feed a reference model
// (byte queue, FIFO occupancy, overflow flag, divisor); a serial monitor
// decodes every txd frame and compares it with the queued byte.
module tb_mmio_uart_tx;
    import mmio_uart_pkg::*;

    localparam logic [31:0] BASE     = 32'hf000_0000;
    localparam logic [31:0] A_DATA   = UART_DATA_ADDR;
    localparam logic [31:0] A_STATUS = BASE + 32'h14;
    localparam logic [31:0] A_DIV    = BASE + 32'h18;
    localparam int DEPTH      = 16;
    localparam int DBITS      = 8;
    localparam int SBITS      = 1;
    localparam int FRAME_BITS = 1 + DBITS + SBITS;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] dataIn = '0;
    logic [2:0]  func3 = '0;
    logic [31:0] dataOut;
    logic        txd;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [7:0] expQ[$];
    int fifoCount = 0;
    bit inFrame = 0;
    bit modelOvf = 0;
    int modelDiv = 4;
    bit abortMon = 0;

    always #5 clock = ~clock;

    mmio_uart_tx #(
        .BASE       (BASE),
        .FIFO_DEPTH (DEPTH),
        .DIV_RESET  (16'd4),
        .DATA_BITS  (DBITS),
        .STOP_BITS  (SBITS)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .func3   (func3),
        .write   (write),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .txd     (txd),
        .busy    (busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] expStatus();
        logic [31:0] s;
        s = '0;
        s[0] = (fifoCount == DEPTH);
        s[1] = (fifoCount == 0);
        s[2] = (fifoCount != 0) || inFrame;
        s[3] = modelOvf;
        s[15:8] = 8'(fifoCount);
        return s;
    endfunction

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        address = a;
        dataIn  = d;
        func3   = 3'($urandom_range(0, 2));
        write   = 1'b1;
        @(posedge clock);
        #1;
        write = 1'b0;
        if (a == A_DATA) begin
            if (fifoCount == DEPTH) modelOvf = 1;
            else begin
                fifoCount++;
                expQ.push_back(d[7:0]);
            end
        end else if (a == A_STATUS) begin
            if (d[3]) modelOvf = 0;
        end else if (a == A_DIV) begin
            modelDiv = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
        end
    endtask

    task automatic busRead(input string name, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clock);
        address = a;
        #1;
        check(name, dataOut, exp);
    endtask

    task automatic checkStatus(input string name);
        @(negedge clock);
        address = A_STATUS;
        #1;
        check(name, dataOut, expStatus());
    endtask

    task automatic waitFall(input string name, input int limit);
        int n;
        n = 0;
        @(negedge clock);
        while (txd !== 1'b0 && n < limit) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (txd !== 1'b0) begin
            fails++;
            $display("FAIL %s: txd=%b after %0d cycles, required 0", name, txd, n);
        end
    endtask

    task automatic waitIdle(input string name, input int limit);
        int n;
        n = 0;
        while ((busy !== 1'b0 || expQ.size() != 0) && n < limit) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (busy !== 1'b0 || expQ.size() != 0) begin
            fails++;
            $display("FAIL %s: busy=%b pending=%0d after %0d cycles, required 0/0",
                     name, busy, expQ.size(), n);
        end
        @(negedge clock);
    endtask

    // Serial monitor: samples txd on every falling clock edge, so each bit
    // of period D is seen as exactly D consecutive samples.
    initial begin : monitor
        logic prevTxd;
        logic [FRAME_BITS-1:0] expBits;
        logic [FRAME_BITS-1:0] obsBits;
        logic [7:0] expByte;
        int divAtNeg;
        int b;
        int j;
        int period;
        int frameNo;
        bit ok;
        bit known;
        bit expectStart;
        prevTxd = 1'b1;
        divAtNeg = modelDiv;
        expectStart = 0;
        frameNo = 0;
        forever begin
            @(negedge clock);
            if (abortMon) begin
                abortMon = 0;
                expectStart = 0;
            end else if (expectStart) begin
                expectStart = 0;
                tests++;
                if (txd !== 1'b0) begin
                    fails++;
                    $display("FAIL idle gap: txd=%b one clock after stop, required 0", txd);
                end
            end
            if (prevTxd === 1'b1 && txd === 1'b0) begin
                known = (expQ.size() > 0);
                expByte = known ? expQ.pop_front() : 8'h00;
                if (fifoCount > 0) fifoCount--;
                inFrame = 1;
                expBits = {{SBITS{1'b1}}, expByte, 1'b0};
                obsBits = '0;
                ok = known;
                b = 0;
                j = 0;
                period = divAtNeg;
                while (b < FRAME_BITS && !abortMon) begin
                    if (j == 0) obsBits[b] = txd;
                    if (txd !== expBits[b]) ok = 0;
                    j++;
                    if (j >= period) begin
                        j = 0;
                        b++;
                        period = modelDiv;
                    end
                    @(negedge clock);
                end
                if (abortMon) begin
                    abortMon = 0;
                end else begin
                    inFrame = 0;
                    if (txd !== 1'b1) ok = 0;
                    tests++;
                    if (!ok) begin
                        fails++;
                        $display("FAIL frame %0d: got bits %b (per-bit timing or idle wrong if equal), required %b%s",
                                 frameNo, obsBits, expBits, known ? "" : " (no byte queued)");
                    end
                    frameNo++;
                    expectStart = (fifoCount > 0);
                end
            end
            prevTxd = txd;
            divAtNeg = modelDiv;
        end
    end

    initial begin : stimulus
        int c;
        int op;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state and decode.
        check("reset txd", 32'(txd), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        checkStatus("reset status");
        busRead("reset div", A_DIV, 32'd4);
        busRead("data reads 0", A_DATA, 32'd0);
        busRead("unmapped offset", BASE + 32'h1c, 32'd0);
        busRead("other base", 32'he000_0014, 32'd0);
        busWrite(32'he000_0010, 32'h55);
        checkStatus("unmapped write ignored");

        // Single 0x41 frame; busy falls 40 clocks after the pop.
        busWrite(A_DATA, 32'h41);
        waitFall("first start", 20);
        c = 0;
        while (busy === 1'b1 && c < 200) begin
            @(negedge clock);
            c++;
        end
        check("busy fall after pop", c, 32'd40);
        checkStatus("idle after frame");

        // Back-to-back bytes: level snapshots during the burst.
        busWrite(A_DATA, 32'h12);
        busWrite(A_DATA, 32'hA5);
        busWrite(A_DATA, 32'h7E);
        checkStatus("level after burst");
        repeat (6) begin
            repeat (20) @(negedge clock);
            checkStatus("status during burst");
        end
        waitIdle("burst drain", 400);

        // Overflow: first byte goes into flight, then 16 fill, one dropped.
        busWrite(A_DIV, 32'd100);
        busRead("div 100", A_DIV, 32'd100);
        for (int i = 0; i < DEPTH + 2; i++) busWrite(A_DATA, $urandom);
        checkStatus("overflow status model");
        busRead("overflow status value", A_STATUS, 32'h0000_100D);
        busWrite(A_STATUS, 32'h8);
        checkStatus("overflow cleared");
        busWrite(A_DIV, 32'd0);
        busRead("div 0 stores 1", A_DIV, 32'd1);
        waitIdle("overflow drain", 3000);
        checkStatus("after overflow drain");

        // DIV 4 -> 8 in the middle of data bit 3.
        busWrite(A_DIV, 32'd4);
        busWrite(A_DATA, 32'h5A);
        waitFall("div change start", 20);
        repeat (16) @(negedge clock);
        busWrite(A_DIV, 32'd8);
        busRead("div 8", A_DIV, 32'd8);
        waitIdle("div change drain", 200);

        // Randomized traffic at a few divisors.
        for (int round = 0; round < 3; round++) begin
            busWrite(A_DIV, 32'($urandom_range(1, 3)));
            for (int r = 0; r < 40; r++) begin
                op = $urandom_range(0, 9);
                if (op < 6) busWrite(A_DATA, $urandom);
                else if (op < 8) checkStatus("random status");
                else if (op == 8) busWrite(A_STATUS, 32'h8);
                else repeat ($urandom_range(1, 30)) @(negedge clock);
            end
            waitIdle("random drain", 3000);
        end

        // Reset in the middle of the data bits.
        busWrite(A_DIV, 32'd4);
        busWrite(A_DATA, 32'hC3);
        busWrite(A_DATA, 32'h99);
        waitFall("reset frame start", 20);
        repeat (12) @(negedge clock);
        abortMon = 1;
        #2 reset = 1'b1;
        #1;
        check("txd high on reset", 32'(txd), 32'd1);
        check("busy low on reset", 32'(busy), 32'd0);
        expQ.delete();
        fifoCount = 0;
        inFrame = 0;
        modelOvf = 0;
        modelDiv = 4;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkStatus("status after mid-frame reset");
        busRead("div after mid-frame reset", A_DIV, 32'd4);
        c = 0;
        repeat (60) begin
            @(negedge clock);
            if (txd !== 1'b1) c++;
        end
        check("no residual bits", c, 32'd0);

        check("leftover expected frames", expQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
